// File: rtl/disp7seg_scan.sv
// Multiplexed DIGITS-wide 7-segment scanner with tear-free frame-boundary updates.
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
module disp7seg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   valor,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [7:0]            sieteseg_a2g_dp,
  output logic [DIGITS-1:0]     anodo,
  output logic                  frame_done
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  logic [DW-1:0]         div;
  logic [IW-1:0]         idx;
  logic                  div_wrap;
  logic                  boundary;

  logic [4*DIGITS-1:0]   pend_val;
  logic [DIGITS-1:0]     pend_dp;
  logic [DIGITS-1:0]     pend_blank;
  logic                  pend_valid;

  logic [4*DIGITS-1:0]   disp_val;
  logic [DIGITS-1:0]     disp_dp;
  logic [DIGITS-1:0]     disp_blank;
  logic [DIGITS-1:0]     eff_blank;

  logic                  in_guard;
  logic [3:0]            nib;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign div_wrap = (div == DW'(REFRESH_DIV - 1));
  assign boundary = div_wrap && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (div_wrap) begin
      div <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // A load coinciding with the boundary bypasses pending so it is not delayed a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      pend_valid <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_blank <= '1;
    end else begin
      if (load) begin
        pend_val   <= valor;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_valid <= 1'b1;
      end
      if (boundary) begin
        if (load) begin
          disp_val   <= valor;
          disp_dp    <= dp_in;
          disp_blank <= blank_in;
          pend_valid <= 1'b0;
        end else if (pend_valid) begin
          disp_val   <= pend_val;
          disp_dp    <= pend_dp;
          disp_blank <= pend_blank;
          pend_valid <= 1'b0;
        end
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic higher_dark;

  // Walk from the most significant digit down; digit 0 is never suppressed.
  always_comb begin
    eff_blank   = disp_blank;
    higher_dark = 1'b1;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      if (higher_dark && (disp_val[4*(DIGITS-1-k) +: 4] == 4'h0) && !disp_dp[DIGITS-1-k])
        eff_blank[DIGITS-1-k] = 1'b1;
      higher_dark = higher_dark &&
                    ((disp_val[4*(DIGITS-1-k) +: 4] == 4'h0) || eff_blank[DIGITS-1-k]);
    end
  end
`else
  assign eff_blank = disp_blank;
`endif

  assign in_guard = (int'(div) < GUARD);
  assign nib      = disp_val[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sieteseg_a2g_dp <= 8'hFF;
      anodo           <= '1;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (in_guard) begin
        anodo           <= '1;
        sieteseg_a2g_dp <= 8'hFF;
      end else begin
        anodo           <= ~(DIGITS'(1) << idx);
        sieteseg_a2g_dp <= eff_blank[idx] ? 8'hFF : {seg7(nib), ~disp_dp[idx]};
      end
    end
  end

endmodule

// File: tb/tb_disp7seg_scan.sv
// Scoreboard bench for disp7seg_scan (DIGITS=4, REFRESH_DIV=4, GUARD=1).
module tb_disp7seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] valor;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [7:0]  sieteseg_a2g_dp;
  logic [3:0]  anodo;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

  disp7seg_scan #(.DIGITS(4), .REFRESH_DIV(4), .GUARD(1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load            (load),
    .valor           (valor),
    .dp_in           (dp_in),
    .blank_in        (blank_in),
    .sieteseg_a2g_dp (sieteseg_a2g_dp),
    .anodo           (anodo),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[n];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Expected {anodo, seg} for the 16 output samples of one frame.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    logic [3:0] an;
    logic [3:0] n;
    logic [7:0] sg;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          exp_q.push_back({4'hF, 8'hFF});
        end else begin
          an = ~(4'b0001 << s);
          n  = v[4*s +: 4];
          sg = bl[s] ? 8'hFF : {ref_seg(n), ~dp[s]};
          exp_q.push_back({an, sg});
        end
      end
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
  endtask

  // Called on a frame_done sample; checks the next 16 samples and optionally loads at samples ld1/ld2.
  task automatic check_frame(input int ld1, input int ld2, input logic [15:0] v1,
                             input logic [15:0] v2, input logic [3:0] dp, input logic [3:0] bl);
    logic [11:0] e;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("anodo k=%0d", k), {28'd0, anodo}, {28'd0, e[11:8]});
        chk($sformatf("seg k=%0d", k), {24'd0, sieteseg_a2g_dp}, {24'd0, e[7:0]});
      end
      chk($sformatf("frame_done k=%0d", k), {31'd0, frame_done}, {31'd0, (k == 16)});
      load     = (k == ld1) || (k == ld2);
      valor    = (k == ld2) ? v2 : v1;
      dp_in    = dp;
      blank_in = bl;
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; valor = '0; dp_in = '0; blank_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_anodo", {28'd0, anodo}, 32'hF);
    chk("rst_seg", {24'd0, sieteseg_a2g_dp}, 32'hFF);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    wait_frame();

    repeat (3) begin
      push_frame(16'h0000, 4'h0, 4'hF);
      check_frame(0, 0, 16'h0, 16'h0, 4'h0, 4'h0);
    end

    push_frame(16'h0000, 4'h0, 4'hF);
    check_frame(3, 0, 16'h12AF, 16'h0, 4'b0010, 4'b0000);
    push_frame(16'h12AF, 4'b0010, 4'b0000);
    check_frame(5, 7, 16'h0000, 16'h8888, 4'h0, 4'h0);
    push_frame(16'h8888, 4'h0, 4'h0);
    check_frame(15, 0, 16'h5555, 16'h0, 4'h0, 4'h0);
    push_frame(16'h5555, 4'h0, 4'h0);
    check_frame(2, 0, 16'h3333, 16'h0, 4'h0, 4'b0100);
    push_frame(16'h3333, 4'h0, 4'b0100);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame(4, 0, 16'h0070, 16'h0, 4'h0, 4'h0);
    push_frame(16'h0070, 4'h0, 4'b1100);
    check_frame(4, 0, 16'h0000, 16'h0, 4'h0, 4'h0);
    push_frame(16'h0000, 4'h0, 4'b1110);
    check_frame(0, 0, 16'h0, 16'h0, 4'h0, 4'h0);
`else
    check_frame(0, 0, 16'h0, 16'h0, 4'h0, 4'h0);
`endif

    // Mid-scan reset discards a pending load.
    @(negedge clk);
    load = 1'b1; valor = 16'h9999; dp_in = '0; blank_in = '0;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_anodo", {28'd0, anodo}, 32'hF);
    chk("midrst_seg", {24'd0, sieteseg_a2g_dp}, 32'hFF);
    chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame();
    push_frame(16'h0000, 4'h0, 4'hF);
    check_frame(0, 0, 16'h0, 16'h0, 4'h0, 4'h0);
    push_frame(16'h0000, 4'h0, 4'hF);
    check_frame(0, 0, 16'h0, 16'h0, 4'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
